// File: rtl/riscv_pkg.sv
// Shared encodings for the multicycle RISC-V control path: FSM states,
// ALU and mux select codes, and the base-ISA major opcodes.
package riscv_pkg;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        EXEC_R   = 4'd2,
        EXEC_I   = 4'd3,
        MEM_ADDR = 4'd4,
        MEM_RD   = 4'd5,
        MEM_WR   = 4'd6,
        WB_MEM   = 4'd7,
        WB_ALU   = 4'd8,
        BRANCH   = 4'd9,
        JAL      = 4'd10,
        JALR     = 4'd11,
        LUI      = 4'd12,
        AUIPC    = 4'd13,
        TRAP     = 4'd14
    } state_t;

    typedef enum logic [1:0] {
        ALU_ADD   = 2'b00,
        ALU_SUB   = 2'b01,
        ALU_RTYPE = 2'b10,
        ALU_ITYPE = 2'b11
    } alu_op_t;

    typedef enum logic [1:0] {
        SRC_A_OLD_PC = 2'b00,
        SRC_A_RS1    = 2'b01,
        SRC_A_ZERO   = 2'b10
    } src_a_t;

    typedef enum logic [1:0] {
        SRC_B_RS2  = 2'b00,
        SRC_B_IMM  = 2'b01,
        SRC_B_FOUR = 2'b10
    } src_b_t;

    typedef enum logic [1:0] {
        WB_ALUOUT   = 2'b00,
        WB_MEM_DATA = 2'b01,
        WB_PC4      = 2'b10
    } wb_sel_t;

    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

endpackage

// File: rtl/opcode_decode.sv
// Combinational opcode decode: the state to enter after DECODE, plus a
// load/store discriminator used when leaving MEM_ADDR.
module opcode_decode
    import riscv_pkg::*;
(
    input  logic [6:0] opcode,
    output logic [3:0] decode_state,
    output logic       is_load
);

    always_comb begin
        decode_state = TRAP;
        case (opcode)
            OP_RTYPE:           decode_state = EXEC_R;
            OP_ITYPE:           decode_state = EXEC_I;
            OP_LOAD, OP_STORE:  decode_state = MEM_ADDR;
            OP_BRANCH:          decode_state = BRANCH;
            OP_JAL:             decode_state = JAL;
            OP_JALR:            decode_state = JALR;
            OP_LUI:             decode_state = LUI;
            OP_AUIPC:           decode_state = AUIPC;
            default:            decode_state = TRAP;
        endcase
    end

    assign is_load = (opcode == OP_LOAD);

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle RV32 main control FSM: sequences fetch, decode, execute, memory
// and write-back phases and drives the datapath mux/enable controls.
module multicycle_ctrl
    import riscv_pkg::*;
(
    input  logic       clk,
    input  logic       n_rst,
    input  logic [6:0] opcode,
    input  logic       branch_taken,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       ir_write,
    output logic       reg_write,
    output logic       mem_req,
    output logic       mem_we,
    output logic       illegal,
    output logic       instret,
    output logic [1:0] ALUOp,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic       pc_src,
    output logic [1:0] wb_sel
);

    state_t     state_reg;
    state_t     state_next;
    logic       instret_reg;
    logic [3:0] decode_state;
    logic       is_load;

    alu_op_t    alu_op;
    src_a_t     src_a;
    src_b_t     src_b;
    wb_sel_t    wb;

    opcode_decode u_decode (
        .opcode       (opcode),
        .decode_state (decode_state),
        .is_load      (is_load)
    );

    // State register; instret marks the first cycle of every re-entry to FETCH.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_reg   <= FETCH;
            instret_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            instret_reg <= (state_reg != FETCH) && (state_next == FETCH);
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            FETCH:    if (mem_ready) state_next = DECODE;
            DECODE:   state_next = state_t'(decode_state);
            EXEC_R:   state_next = WB_ALU;
            EXEC_I:   state_next = WB_ALU;
            LUI:      state_next = WB_ALU;
            AUIPC:    state_next = WB_ALU;
            MEM_ADDR: state_next = is_load ? MEM_RD : MEM_WR;
            MEM_RD:   if (mem_ready) state_next = WB_MEM;
            MEM_WR:   if (mem_ready) state_next = FETCH;
            WB_MEM:   state_next = FETCH;
            WB_ALU:   state_next = FETCH;
            BRANCH:   state_next = FETCH;
            JAL:      state_next = FETCH;
            JALR:     state_next = FETCH;
            TRAP:     state_next = TRAP;
            default:  state_next = FETCH;
        endcase
    end

    // Outputs are gated by n_rst so an in-flight memory request drops the
    // moment reset is asserted, without waiting for a clock edge.
    always_comb begin
        pc_write  = 1'b0;
        ir_write  = 1'b0;
        reg_write = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        illegal   = 1'b0;
        pc_src    = 1'b0;
        alu_op    = ALU_ADD;
        src_a     = SRC_A_OLD_PC;
        src_b     = SRC_B_RS2;
        wb        = WB_ALUOUT;
        if (n_rst) begin
            case (state_reg)
                FETCH: begin
                    mem_req  = 1'b1;
                    src_b    = SRC_B_FOUR;
                    ir_write = mem_ready;
                    pc_write = mem_ready;
                end
                DECODE: begin
                    src_b = SRC_B_IMM;
                end
                EXEC_R: begin
                    alu_op = ALU_RTYPE;
                    src_a  = SRC_A_RS1;
                    src_b  = SRC_B_RS2;
                end
                EXEC_I: begin
                    alu_op = ALU_ITYPE;
                    src_a  = SRC_A_RS1;
                    src_b  = SRC_B_IMM;
                end
                MEM_ADDR: begin
                    src_a = SRC_A_RS1;
                    src_b = SRC_B_IMM;
                end
                MEM_RD: begin
                    mem_req = 1'b1;
                end
                MEM_WR: begin
                    mem_req = 1'b1;
                    mem_we  = 1'b1;
                end
                WB_MEM: begin
                    reg_write = 1'b1;
                    wb        = WB_MEM_DATA;
                end
                WB_ALU: begin
                    reg_write = 1'b1;
                    wb        = WB_ALUOUT;
                end
                BRANCH: begin
                    alu_op   = ALU_SUB;
                    src_a    = SRC_A_RS1;
                    src_b    = SRC_B_RS2;
                    pc_write = branch_taken;
                    pc_src   = branch_taken;
                end
                JAL: begin
                    pc_write  = 1'b1;
                    pc_src    = 1'b1;
                    reg_write = 1'b1;
                    wb        = WB_PC4;
                end
                JALR: begin
                    src_a     = SRC_A_RS1;
                    src_b     = SRC_B_IMM;
                    pc_write  = 1'b1;
                    reg_write = 1'b1;
                    wb        = WB_PC4;
                end
                LUI: begin
                    src_a = SRC_A_ZERO;
                    src_b = SRC_B_IMM;
                end
                AUIPC: begin
                    src_a = SRC_A_OLD_PC;
                    src_b = SRC_B_IMM;
                end
                TRAP: begin
                    illegal = 1'b1;
                end
                default: begin
                    illegal = 1'b0;
                end
            endcase
        end
    end

    assign instret   = instret_reg;
    assign ALUOp     = alu_op;
    assign alu_src_a = src_a;
    assign alu_src_b = src_b;
    assign wb_sel    = wb;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized bench for multicycle_ctrl: each instruction class is expanded
// into its expected per-cycle control trace and compared cycle by cycle.
module tb_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       n_rst;
    logic [6:0] opcode;
    logic       branch_taken;
    logic       mem_ready;
    logic       pc_write, ir_write, reg_write, mem_req, mem_we, illegal, instret;
    logic [1:0] ALUOp, alu_src_a, alu_src_b, wb_sel;
    logic       pc_src;

    typedef struct packed {
        logic       pcw;
        logic       irw;
        logic       rw;
        logic       mreq;
        logic       mwe;
        logic       ill;
        logic       ret;
        logic [1:0] aop;
        logic [1:0] sa;
        logic [1:0] sb;
        logic       psrc;
        logic [1:0] wb;
    } outs_t;

    typedef struct {
        outs_t exp;
        logic  ready;
        logic  taken;
    } cyc_t;

    cyc_t  plan[$];
    outs_t obs;
    int    checks = 0;
    int    failures = 0;
    bit    after_reset;
    bit    hold_ready;

    localparam int C_R = 0, C_I = 1, C_LOAD = 2, C_STORE = 3, C_BR = 4;
    localparam int C_JAL = 5, C_JALR = 6, C_LUI = 7, C_AUIPC = 8, C_ILL = 9;

    multicycle_ctrl dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .opcode       (opcode),
        .branch_taken (branch_taken),
        .mem_ready    (mem_ready),
        .pc_write     (pc_write),
        .ir_write     (ir_write),
        .reg_write    (reg_write),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .illegal      (illegal),
        .instret      (instret),
        .ALUOp        (ALUOp),
        .alu_src_a    (alu_src_a),
        .alu_src_b    (alu_src_b),
        .pc_src       (pc_src),
        .wb_sel       (wb_sel)
    );

    always #5 clk = ~clk;

    assign obs = {pc_write, ir_write, reg_write, mem_req, mem_we, illegal, instret,
                  ALUOp, alu_src_a, alu_src_b, pc_src, wb_sel};

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic dc_ready();
        return hold_ready ? 1'b1 : 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [6:0] op_of(input int cls);
        case (cls)
            C_R:     return 7'b0110011;
            C_I:     return 7'b0010011;
            C_LOAD:  return 7'b0000011;
            C_STORE: return 7'b0100011;
            C_BR:    return 7'b1100011;
            C_JAL:   return 7'b1101111;
            C_JALR:  return 7'b1100111;
            C_LUI:   return 7'b0110111;
            C_AUIPC: return 7'b0010111;
            default: return 7'b0000000;
        endcase
    endfunction

    function automatic bit is_legal(input logic [6:0] op);
        for (int c = 0; c < C_ILL; c++)
            if (op_of(c) == op) return 1'b1;
        return 1'b0;
    endfunction

    task automatic push(input outs_t e, input logic r, input logic t);
        cyc_t c;
        c.exp = e;
        c.ready = r;
        c.taken = t;
        plan.push_back(c);
    endtask

    // Expected control trace of one instruction, phase by phase.
    task automatic plan_instr(input int cls, input int fw, input int dw, input logic tk);
        outs_t e;
        outs_t wb_alu;
        wb_alu = '0;
        wb_alu.rw = 1'b1;
        plan.delete();
        for (int i = 0; i < fw; i++) begin
            e = '0; e.mreq = 1'b1; e.sb = 2'b10;
            e.ret = (i == 0) && !after_reset;
            push(e, 1'b0, 1'($urandom_range(0, 1)));
        end
        e = '0; e.mreq = 1'b1; e.sb = 2'b10; e.irw = 1'b1; e.pcw = 1'b1;
        e.ret = (fw == 0) && !after_reset;
        push(e, 1'b1, 1'($urandom_range(0, 1)));
        e = '0; e.sb = 2'b01;
        push(e, dc_ready(), 1'($urandom_range(0, 1)));
        case (cls)
            C_R, C_I: begin
                e = '0; e.aop = (cls == C_R) ? 2'b10 : 2'b11; e.sa = 2'b01;
                e.sb = (cls == C_R) ? 2'b00 : 2'b01;
                push(e, dc_ready(), 1'($urandom_range(0, 1)));
                push(wb_alu, dc_ready(), 1'($urandom_range(0, 1)));
            end
            C_LOAD, C_STORE: begin
                e = '0; e.sa = 2'b01; e.sb = 2'b01;
                push(e, dc_ready(), 1'($urandom_range(0, 1)));
                e = '0; e.mreq = 1'b1; e.mwe = (cls == C_STORE);
                for (int i = 0; i < dw; i++) push(e, 1'b0, 1'($urandom_range(0, 1)));
                push(e, 1'b1, 1'($urandom_range(0, 1)));
                if (cls == C_LOAD) begin
                    e = '0; e.rw = 1'b1; e.wb = 2'b01;
                    push(e, dc_ready(), 1'($urandom_range(0, 1)));
                end
            end
            C_BR: begin
                e = '0; e.aop = 2'b01; e.sa = 2'b01; e.pcw = tk; e.psrc = tk;
                push(e, dc_ready(), tk);
            end
            C_JAL: begin
                e = '0; e.pcw = 1'b1; e.psrc = 1'b1; e.rw = 1'b1; e.wb = 2'b10;
                push(e, dc_ready(), 1'($urandom_range(0, 1)));
            end
            C_JALR: begin
                e = '0; e.sa = 2'b01; e.sb = 2'b01; e.pcw = 1'b1; e.rw = 1'b1; e.wb = 2'b10;
                push(e, dc_ready(), 1'($urandom_range(0, 1)));
            end
            C_LUI, C_AUIPC: begin
                e = '0; e.sa = (cls == C_LUI) ? 2'b10 : 2'b00; e.sb = 2'b01;
                push(e, dc_ready(), 1'($urandom_range(0, 1)));
                push(wb_alu, dc_ready(), 1'($urandom_range(0, 1)));
            end
            default: begin
                e = '0; e.ill = 1'b1;
                for (int i = 0; i < 5; i++)
                    push(e, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            end
        endcase
    endtask

    task automatic run_plan(input string tag);
        cyc_t c;
        while (plan.size() > 0) begin
            c = plan.pop_front();
            @(negedge clk);
            mem_ready = c.ready;
            branch_taken = c.taken;
            #1;
            check(tag, obs, c.exp);
        end
    endtask

    task automatic run_instr(input int cls, input logic [6:0] op, input int fw,
                             input int dw, input logic tk);
        int n;
        opcode = op;
        plan_instr(cls, fw, dw, tk);
        n = plan.size();
        $display("instr op=%b cls=%0d fw=%0d dw=%0d taken=%0d cycles=%0d",
                 op, cls, fw, dw, tk, n);
        run_plan($sformatf("instr_op%b", op));
        after_reset = 1'b0;
    endtask

    // Called just after a negedge check; reset is pulsed mid-cycle and released
    // just after a posedge so the next planned cycle is the first FETCH.
    task automatic pulse_reset(input string tag);
        #1 n_rst = 1'b0;
        #1 check({tag, "_async"}, obs, 16'h0000);
        @(negedge clk);
        mem_ready = 1'($urandom_range(0, 1));
        #1 check({tag, "_hold"}, obs, 16'h0000);
        @(posedge clk);
        #1 n_rst = 1'b1;
        mem_ready = 1'b0;
        after_reset = 1'b1;
        $display("reset pulse %s", tag);
    endtask

    task automatic run_random(input int count);
        int cls;
        for (int k = 0; k < count; k++) begin
            cls = $urandom_range(0, C_AUIPC);
            run_instr(cls, op_of(cls), $urandom_range(0, 2), $urandom_range(0, 3),
                      1'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        logic [6:0] bad_op;
        n_rst = 1'b0;
        opcode = 7'd0;
        mem_ready = 1'b0;
        branch_taken = 1'b0;
        hold_ready = 1'b0;
        after_reset = 1'b1;

        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            mem_ready = 1'($urandom_range(0, 1));
            #1 check("reset_outputs", obs, 16'h0000);
        end
        @(posedge clk);
        #1 n_rst = 1'b1;
        mem_ready = 1'b0;

        hold_ready = 1'b1;
        run_instr(C_R, op_of(C_R), 0, 0, 1'b0);
        hold_ready = 1'b0;
        run_instr(C_LOAD, op_of(C_LOAD), 0, 3, 1'b0);
        run_instr(C_BR, op_of(C_BR), 0, 0, 1'b1);
        run_instr(C_BR, op_of(C_BR), 1, 0, 1'b0);
        run_instr(C_JAL, op_of(C_JAL), 0, 0, 1'b0);
        run_instr(C_I, op_of(C_I), 2, 0, 1'b0);
        run_instr(C_JALR, op_of(C_JALR), 0, 0, 1'b0);
        run_instr(C_LUI, op_of(C_LUI), 1, 0, 1'b0);
        run_instr(C_AUIPC, op_of(C_AUIPC), 0, 0, 1'b0);
        run_instr(C_STORE, op_of(C_STORE), 1, 2, 1'b0);
        run_random(40);

        // Store interrupted by reset during its second data wait cycle.
        opcode = op_of(C_STORE);
        plan_instr(C_STORE, 0, 3, 1'b0);
        void'(plan.pop_back());
        void'(plan.pop_back());
        $display("instr op=%b cls=%0d interrupted by reset", opcode, C_STORE);
        run_plan("sw_before_reset");
        pulse_reset("sw_reset");
        run_random(10);

        run_instr(C_ILL, 7'b0000000, 0, 0, 1'b0);
        pulse_reset("trap_reset");
        run_random(10);

        do bad_op = 7'($urandom_range(0, 127)); while (is_legal(bad_op));
        run_instr(C_ILL, bad_op, 1, 0, 1'b0);
        pulse_reset("trap2_reset");
        run_random(5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
